ahb_sub_csr_mux: RTL and testbench

- Multi-target AHB subordinate to CSR bridge; fans one AHB port out to NUM_TGT CSR targets selected by address bits.
- Adds narrow (byte/halfword) writes with strobes, a two-cycle ERROR response for illegal accesses, and a per-access timeout.
- Sits between the AHB interconnect and CSR register blocks.
- Response is always flopped: one wait state minimum.

---
 rtl/ahb_sub_csr_mux_pkg.sv | 43 ++++
 rtl/ahb_sub_csr_mux_timeout.sv | 37 +++
 rtl/ahb_sub_csr_mux.sv | 140 ++++++++++++++
 tb/tb_ahb_sub_csr_mux.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sub_csr_mux_pkg.sv
// Shared AHB types, legality/strobe helpers and bridge state encoding for the
// AHB subordinate to multi-target CSR bridge.
package ahb_sub_csr_mux_pkg;

   localparam int DW  = 32;
   localparam int NB  = DW / 8;
   localparam int LNB = $clog2(NB);

   typedef logic [31:0]   haddr_t;
   typedef logic [DW-1:0] hdata_t;
   typedef logic [2:0]    hsize_t;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [2:0] {IDLE, VALID, RESP, ERR1, ERR2} csr_mux_state_e;

   // Size must fit the bus and the address must be naturally aligned to it.
   function automatic logic ahb_size_ok(input hsize_t hsize, input haddr_t addr, input int nb);
      logic [31:0] bytes;
      bytes = 32'd1 << hsize;
      if (bytes > 32'(nb)) return 1'b0;
      return (addr & (bytes - 32'd1)) == 32'd0;
   endfunction

   function automatic logic [NB-1:0] ahb_wstrb(input hsize_t hsize, input haddr_t addr, input int nb);
      logic [31:0] ones;
      logic [31:0] off;
      ones = (32'd1 << (32'd1 << hsize)) - 32'd1;
      off  = addr & 32'(nb - 1);
      return NB'(ones << off);
   endfunction

endpackage

// File: rtl/ahb_sub_csr_mux_timeout.sv
// Access timeout counter: clears while idle, counts enabled cycles and flags
// the last permitted cycle. TIMEOUT_CYC = 0 disables expiry entirely.
module ahb_sub_csr_mux_timeout #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   generate
      if (TIMEOUT_CYC == 0) begin : g_off
         logic unused_tmo;
         assign unused_tmo = ^{clk_i, rst_i, clr_i, en_i};
         assign expire_o   = 1'b0;
      end else begin : g_on
         localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
         logic [CW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clr_i)     cnt_d = '0;
            else if (en_i) cnt_d = cnt_q + 1'b1;
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) cnt_q <= '0;
            else       cnt_q <= cnt_d;
         end

         assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
      end
   endgenerate

endmodule

// File: rtl/ahb_sub_csr_mux.sv
// AHB subordinate fanning out to NUM_TGT CSR targets selected by haddr bits
// above TGT_LSB, with narrow-write strobes, two-cycle ERROR and access timeout.
module ahb_sub_csr_mux
   import ahb_sub_csr_mux_pkg::*;
#(
   parameter int NUM_TGT      = 4,
   parameter int TGT_LSB      = 12,
   parameter int TIMEOUT_CYC  = 256,
   parameter int ALLOW_NARROW = 1
) (
   input  logic                        hclk_i,
   input  logic                        hreset_i,
   input  logic                        hsel_i,
   input  haddr_t                      haddr_i,
   input  htrans_e                     htrans_i,
   input  hsize_t                      hsize_i,
   input  logic                        hwrite_i,
   input  hdata_t                      hwdata_i,
   input  logic                        hready_i,
   output hdata_t                      hrdata_o,
   output hresp_e                      hresp_o,
   output logic                        hready_o,
   output logic [NUM_TGT-1:0]          sub_valid_o,
   input  logic [NUM_TGT-1:0]          sub_ready_i,
   output haddr_t                      sub_addr_o,
   output logic                        sub_write_o,
   output hdata_t                      sub_wdata_o,
   output logic [NB-1:0]               sub_wstrb_o,
   input  logic [NUM_TGT-1:0][DW-1:0]  sub_rdata_i
);

   localparam int     TW   = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam hsize_t FULL = hsize_t'(LNB);

   csr_mux_state_e    state_q, state_d;
   logic              hready_q, hready_d;
   hresp_e            hresp_q, hresp_d;
   logic [NUM_TGT-1:0] valid_q, valid_d;
   haddr_t            addr_q, addr_d;
   logic              write_q, write_d;
   logic [NB-1:0]     wstrb_q, wstrb_d;
   logic [TW-1:0]     idx_q, idx_d;
   hdata_t            rdata_q, rdata_d;

   haddr_t tgt_field;
   logic   accept, legal, sel_ready, expire, tmo_en, tmo_clr;

   // The whole field above TGT_LSB is decoded so aliases beyond NUM_TGT error out.
   assign tgt_field = haddr_i >> TGT_LSB;
   assign accept    = hsel_i && hready_i &&
                      (htrans_i == HTRANS_NONSEQ || htrans_i == HTRANS_SEQ);
   assign legal     = (tgt_field < 32'(NUM_TGT)) &&
                      ahb_size_ok(hsize_i, haddr_i, NB) &&
                      (hwrite_i || hsize_i == FULL) &&
                      ((ALLOW_NARROW != 0) || hsize_i == FULL);
   assign sel_ready = sub_ready_i[idx_q];
   assign tmo_en    = (state_q == VALID);
   assign tmo_clr   = (state_q != VALID);

   ahb_sub_csr_mux_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk_i    (hclk_i),
      .rst_i    (hreset_i),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expire_o (expire)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wstrb_d = wstrb_q;
      idx_d   = idx_q;
      rdata_d = rdata_q;
      case (state_q)
         VALID: begin
            // Ready takes priority over a coincident timeout.
            if (sel_ready) begin
               state_d = RESP;
               if (!write_q) rdata_d = sub_rdata_i[idx_q];
            end else if (expire) begin
               state_d = ERR1;
            end
         end
         ERR1: state_d = ERR2;
         default: begin
            if (accept && legal) begin
               state_d = VALID;
               addr_d  = haddr_i;
               write_d = hwrite_i;
               wstrb_d = hwrite_i ? ahb_wstrb(hsize_i, haddr_i, NB) : '1;
               idx_d   = tgt_field[TW-1:0];
            end else if (accept) begin
               state_d = ERR1;
            end else begin
               state_d = IDLE;
            end
         end
      endcase

      hready_d = !(state_d == VALID || state_d == ERR1);
      hresp_d  = (state_d == ERR1 || state_d == ERR2) ? HRESP_ERROR : HRESP_OKAY;
      valid_d  = '0;
      if (state_d == VALID) valid_d[idx_d] = 1'b1;
   end

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         state_q  <= IDLE;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
         valid_q  <= '0;
         addr_q   <= '1;
         write_q  <= 1'b0;
         wstrb_q  <= '1;
         idx_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wstrb_q  <= wstrb_d;
         idx_q    <= idx_d;
         rdata_q  <= rdata_d;
      end
   end

   assign hready_o    = hready_q;
   assign hresp_o     = hresp_q;
   assign hrdata_o    = rdata_q;
   assign sub_valid_o = valid_q;
   assign sub_addr_o  = addr_q;
   assign sub_write_o = write_q;
   assign sub_wstrb_o = wstrb_q;
   assign sub_wdata_o = hwdata_i;

endmodule

// File: tb/tb_ahb_sub_csr_mux.sv
// Directed bench for ahb_sub_csr_mux: expected responses are queued at address
// acceptance and compared when the data phase completes (hready_o high).
module tb_ahb_sub_csr_mux;
   import ahb_sub_csr_mux_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              hreset_i, hsel_i, hwrite_i;
   haddr_t            haddr_i;
   htrans_e           htrans_i;
   hsize_t            hsize_i;
   hdata_t            hwdata_i, hrdata_o, sub_wdata_o;
   hresp_e            hresp_o;
   logic              hready_o, sub_write_o;
   logic [3:0]        sub_valid_o, sub_ready_i, sub_wstrb_o;
   haddr_t            sub_addr_o;
   logic [3:0][31:0]  sub_rdata_i;

   ahb_sub_csr_mux #(.NUM_TGT(4), .TGT_LSB(12), .TIMEOUT_CYC(8), .ALLOW_NARROW(1)) dut (
      .hclk_i      (clk),
      .hreset_i    (hreset_i),
      .hsel_i      (hsel_i),
      .haddr_i     (haddr_i),
      .htrans_i    (htrans_i),
      .hsize_i     (hsize_i),
      .hwrite_i    (hwrite_i),
      .hwdata_i    (hwdata_i),
      .hready_i    (hready_o),
      .hrdata_o    (hrdata_o),
      .hresp_o     (hresp_o),
      .hready_o    (hready_o),
      .sub_valid_o (sub_valid_o),
      .sub_ready_i (sub_ready_i),
      .sub_addr_o  (sub_addr_o),
      .sub_write_o (sub_write_o),
      .sub_wdata_o (sub_wdata_o),
      .sub_wstrb_o (sub_wstrb_o),
      .sub_rdata_i (sub_rdata_i)
   );

   typedef struct {
      string       tag;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  valid;
      int          vcyc;
      int          low;
      logic [3:0]  strb;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } item_t;

   item_t       sb[$];
   item_t       pend;
   int          checks = 0, failures = 0;
   int          cyc = 0, vcnt = 0, vcyc = 0, lowcnt = 0, rdy_lat = 1;
   bit          acc_seen;
   logic [3:0]  seen_valid = '0, seen_strb = '0;
   logic        seen_write = 1'b0;
   logic [31:0] seen_addr = '0;
   int          vstart[$], vend[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic item_t mk(input string tag, input logic err, input logic [31:0] rdata,
                                input logic [3:0] valid, input int vc, input int low,
                                input logic [3:0] strb, input logic write,
                                input logic [31:0] addr, input logic [31:0] wdata);
      item_t it;
      it.tag = tag; it.err = err; it.rdata = rdata; it.valid = valid; it.vcyc = vc;
      it.low = low; it.strb = strb; it.write = write; it.addr = addr; it.wdata = wdata;
      return it;
   endfunction

   // One clock: retire the head data phase if it completes at this edge,
   // then observe the new cycle and play the target's ready response.
   task automatic tick();
      item_t it;
      logic  acc;
      acc_seen = 1'b0;
      if (sb.size() > 0 && hready_o === 1'b1) begin
         it = sb.pop_front();
         chk({it.tag, " hresp"},  32'(hresp_o), 32'(it.err));
         chk({it.tag, " hrdata"}, hrdata_o, it.rdata);
         chk({it.tag, " wait"},   32'(lowcnt), 32'(it.low));
         chk({it.tag, " vcyc"},   32'(vcyc), 32'(it.vcyc));
         chk({it.tag, " valid"},  32'(seen_valid), 32'(it.valid));
         if (it.valid != 4'b0) begin
            chk({it.tag, " strb"},  32'(seen_strb), 32'(it.strb));
            chk({it.tag, " write"}, 32'(seen_write), 32'(it.write));
            chk({it.tag, " addr"},  seen_addr, it.addr);
         end
         if (it.write && !it.err) chk({it.tag, " wdata"}, sub_wdata_o, it.wdata);
         lowcnt = 0; vcyc = 0; seen_valid = '0;
      end
      acc = hsel_i && htrans_i[1] && (hready_o === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
         sb.push_back(pend);
         acc_seen = 1'b1;
      end
      if (sb.size() > 0 && hready_o === 1'b0) lowcnt++;
      if (sub_valid_o != 4'b0) begin
         vcnt++;
         vcyc++;
         if (vcnt == 1) begin
            seen_valid = sub_valid_o; seen_strb = sub_wstrb_o;
            seen_write = sub_write_o; seen_addr = sub_addr_o;
            vstart.push_back(cyc);
         end
         sub_ready_i = (vcnt == rdy_lat) ? sub_valid_o : 4'b0;
      end else begin
         if (vcnt > 0) vend.push_back(cyc);
         vcnt = 0;
         sub_ready_i = 4'b0;
      end
   endtask

   task automatic issue(input haddr_t a, input hsize_t sz, input logic wr,
                        input logic [31:0] wd, input item_t it, input bit last);
      bit done;
      done = 1'b0;
      pend = it;
      hsel_i = 1'b1; haddr_i = a; htrans_i = HTRANS_NONSEQ; hsize_i = sz; hwrite_i = wr;
      for (int i = 0; i < 30 && !done; i++) begin
         tick();
         done = acc_seen;
      end
      chk({it.tag, " accepted"}, 32'(done), 32'd1);
      if (last) begin
         hsel_i = 1'b0;
         htrans_i = HTRANS_IDLE;
      end
      hwdata_i = wd;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
      chk({tag, " drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      hreset_i = 1'b1; hsel_i = 1'b0; haddr_i = '0; htrans_i = HTRANS_IDLE;
      hsize_i = 3'd2; hwrite_i = 1'b0; hwdata_i = '0; sub_ready_i = '0;
      sub_rdata_i[0] = 32'h1111_0000;
      sub_rdata_i[1] = 32'h2222_0001;
      sub_rdata_i[2] = 32'hCAFE_0001;
      sub_rdata_i[3] = 32'h4444_0003;

      tick(); tick();
      chk("rst hready", 32'(hready_o), 32'd1);
      chk("rst hresp",  32'(hresp_o), 32'd0);
      chk("rst valid",  32'(sub_valid_o), 32'd0);
      chk("rst addr",   sub_addr_o, 32'hFFFF_FFFF);
      chk("rst write",  32'(sub_write_o), 32'd0);
      chk("rst hrdata", hrdata_o, 32'd0);
      hreset_i = 1'b0;
      tick();

      rdy_lat = 1;
      issue(32'h2004, 3'd2, 1'b0, 32'h0,
            mk("rd_t2", 1'b0, 32'hCAFE_0001, 4'b0100, 1, 1, 4'b1111, 1'b0, 32'h2004, 32'h0), 1'b1);
      drain("rd_t2");

      issue(32'h1003, 3'd0, 1'b1, 32'hAB00_0000,
            mk("wr_b", 1'b0, 32'hCAFE_0001, 4'b0010, 1, 1, 4'b1000, 1'b1, 32'h1003, 32'hAB00_0000), 1'b1);
      drain("wr_b");

      issue(32'h3002, 3'd1, 1'b1, 32'h1234_0000,
            mk("wr_h", 1'b0, 32'hCAFE_0001, 4'b1000, 1, 1, 4'b1100, 1'b1, 32'h3002, 32'h1234_0000), 1'b1);
      drain("wr_h");

      issue(32'h5000, 3'd2, 1'b0, 32'h0,
            mk("bad_tgt", 1'b1, 32'hCAFE_0001, 4'b0, 0, 1, 4'b0, 1'b0, 32'h0, 32'h0), 1'b1);
      chk("bad_tgt err1 hready", 32'(hready_o), 32'd0);
      chk("bad_tgt err1 hresp",  32'(hresp_o), 32'd1);
      drain("bad_tgt");

      issue(32'h0001, 3'd1, 1'b1, 32'h0,
            mk("misalign", 1'b1, 32'hCAFE_0001, 4'b0, 0, 1, 4'b0, 1'b0, 32'h0, 32'h0), 1'b1);
      drain("misalign");

      issue(32'h0000, 3'd0, 1'b0, 32'h0,
            mk("narrow_rd", 1'b1, 32'hCAFE_0001, 4'b0, 0, 1, 4'b0, 1'b0, 32'h0, 32'h0), 1'b1);
      drain("narrow_rd");

      issue(32'h0000, 3'd3, 1'b1, 32'h0,
            mk("oversize", 1'b1, 32'hCAFE_0001, 4'b0, 0, 1, 4'b0, 1'b0, 32'h0, 32'h0), 1'b1);
      drain("oversize");

      rdy_lat = -1;
      issue(32'h3000, 3'd2, 1'b0, 32'h0,
            mk("tmo", 1'b1, 32'hCAFE_0001, 4'b1000, 8, 9, 4'b1111, 1'b0, 32'h3000, 32'h0), 1'b1);
      drain("tmo");

      rdy_lat = 8;
      issue(32'h3008, 3'd2, 1'b0, 32'h0,
            mk("rdy_c8", 1'b0, 32'h4444_0003, 4'b1000, 8, 8, 4'b1111, 1'b0, 32'h3008, 32'h0), 1'b1);
      drain("rdy_c8");

      rdy_lat = 1;
      issue(32'h0000, 3'd2, 1'b0, 32'h0,
            mk("b2b_a", 1'b0, 32'h1111_0000, 4'b0001, 1, 1, 4'b1111, 1'b0, 32'h0000, 32'h0), 1'b0);
      issue(32'h1000, 3'd2, 1'b0, 32'h0,
            mk("b2b_b", 1'b0, 32'h2222_0001, 4'b0010, 1, 1, 4'b1111, 1'b0, 32'h1000, 32'h0), 1'b1);
      chk("b2b gap", 32'(vstart[vstart.size()-1] - vend[vend.size()-1]), 32'd1);
      drain("b2b");

      rdy_lat = -1;
      issue(32'h2000, 3'd2, 1'b0, 32'h0,
            mk("aborted", 1'b0, 32'h0, 4'b0100, 1, 1, 4'b1111, 1'b0, 32'h2000, 32'h0), 1'b1);
      tick(); tick(); tick();
      chk("pre-rst valid", 32'(sub_valid_o), 32'h4);
      hreset_i = 1'b1;
      tick();
      sb.delete();
      lowcnt = 0; vcyc = 0; seen_valid = '0;
      chk("midrst valid",  32'(sub_valid_o), 32'd0);
      chk("midrst hready", 32'(hready_o), 32'd1);
      chk("midrst hresp",  32'(hresp_o), 32'd0);
      chk("midrst hrdata", hrdata_o, 32'd0);
      hreset_i = 1'b0;
      tick();

      issue(32'h1000, 3'd2, 1'b0, 32'h0,
            mk("tmo2", 1'b1, 32'h0, 4'b0010, 8, 9, 4'b1111, 1'b0, 32'h1000, 32'h0), 1'b1);
      drain("tmo2");

      rdy_lat = 2;
      issue(32'h2004, 3'd2, 1'b0, 32'h0,
            mk("rd_lat2", 1'b0, 32'hCAFE_0001, 4'b0100, 2, 2, 4'b1111, 1'b0, 32'h2004, 32'h0), 1'b1);
      drain("rd_lat2");
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
